// File: rtl/tick_scheduler_if.sv
// Config request channel of tick_scheduler: valid/ready handshake, target fields and error pulse.
interface tick_scheduler_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding NUM_CH channels with per-channel tick pulse and 50% divided clock.
// Optional TICK_SCHED_ALIGN_EN adds an align input that re-phases every channel at once.
module tick_scheduler #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned BASE_DIV = 100000,
    parameter int unsigned CNT_W    = 17,
    parameter int unsigned DIV_W    = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
`ifdef TICK_SCHED_ALIGN_EN
    input  logic              align,
`endif
    tick_scheduler_if.slave   cfg,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    if (64'(BASE_DIV) < 64'd2 || 64'(BASE_DIV) > (64'd1 << CNT_W) ||
        64'(NUM_CH) < 64'd1 || 64'(NUM_CH) > (64'd1 << CH_W)) begin : g_bad_params
        $error("tick_scheduler: invalid parameter combination");
    end

    // The apply happens on the edge that leaves PEND, so APPLY is never a resident state.
    typedef enum logic [0:0] {IDLE, PEND} state_e;

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               p_ch_q, p_ch_d;
    logic [DIV_W-1:0]              p_div_q, p_div_d;
    logic                          p_en_q, p_en_d;
    logic                          err_q, err_d;
    logic                          apply;

    logic [CNT_W-1:0]              pre_q, pre_d;
    logic                          bt_q, bt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;
    logic [NUM_CH-1:0]             en_q, en_d;
    logic [NUM_CH-1:0]             clk_q, clk_d;
    logic [NUM_CH-1:0]             tick_q, tick_d;
    logic                          wrap;
    logic [NUM_CH-1:0]             at_bnd;

    assign wrap = (pre_q == CNT_W'(BASE_DIV - 1));

    always_comb begin
        at_bnd = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            at_bnd[c] = wrap && en_q[c] && (cnt_q[c] == div_q[c] - 1'b1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_ch_q  <= '0;
            p_div_q <= '0;
            p_en_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_ch_q  <= p_ch_d;
            p_div_q <= p_div_d;
            p_en_q  <= p_en_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_ch_d  = p_ch_q;
        p_div_d = p_div_q;
        p_en_d  = p_en_q;
        err_d   = 1'b0;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (32'(cfg.cfg_ch) >= NUM_CH) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = PEND;
                        p_ch_d  = cfg.cfg_ch;
                        p_div_d = cfg.cfg_div;
                        p_en_d  = cfg.cfg_en && (cfg.cfg_div != '0);
                    end
                end
            end
            PEND: begin
                if (at_bnd[p_ch_q] || !en_q[p_ch_q]) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg.cfg_ready = (state_q == IDLE);
        cfg.cfg_err   = err_q;
        base_tick     = bt_q;
        tick          = tick_q;
        clk_out       = clk_q;
    end

    always_comb begin
        pre_d  = wrap ? '0 : pre_q + 1'b1;
        bt_d   = wrap;
        cnt_d  = cnt_q;
        div_d  = div_q;
        en_d   = en_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (at_bnd[c]) begin
                cnt_d[c]  = '0;
                tick_d[c] = 1'b1;
                clk_d[c]  = ~clk_q[c];
            end else if (wrap && en_q[c]) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
            // A boundary apply keeps the final tick; disabling forces the clock low.
            if (apply && (32'(p_ch_q) == c)) begin
                div_d[c] = p_div_q;
                en_d[c]  = p_en_q;
                cnt_d[c] = '0;
                if (!p_en_q) begin
                    clk_d[c] = 1'b0;
                end
            end
        end
`ifdef TICK_SCHED_ALIGN_EN
        if (align) begin
            pre_d  = '0;
            bt_d   = 1'b0;
            cnt_d  = '0;
            clk_d  = '0;
            tick_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            bt_q   <= 1'b0;
            cnt_q  <= '0;
            div_q  <= '0;
            en_q   <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            pre_q  <= pre_d;
            bt_q   <= bt_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            en_q   <= en_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with BASE_DIV=4 and NUM_CH=3.
module tb_tick_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] tick;
    logic [2:0] clk_out;
    logic       base_tick;
`ifdef TICK_SCHED_ALIGN_EN
    logic       align = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    tick_scheduler_if #(.CH_W(2), .DIV_W(8)) cfg_if ();

    tick_scheduler #(
        .NUM_CH(3), .CH_W(2), .BASE_DIV(4), .CNT_W(3), .DIV_W(8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
`ifdef TICK_SCHED_ALIGN_EN
        .align    (align),
`endif
        .cfg      (cfg_if),
        .base_tick(base_tick),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] div, input logic en);
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = div;
        cfg_if.cfg_en    = en;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // sel 0..2 waits for tick[sel], sel 3 waits for base_tick; n=-1 when the budget expires
    task automatic wait_ev(input int sel, input int budget, output int n);
        logic hit;
        n = -1;
        hit = 1'b0;
        for (int i = 1; i <= budget && !hit; i++) begin
            step();
            if ((sel == 3) ? base_tick : tick[sel]) begin
                n = i;
                hit = 1'b1;
            end
        end
    endtask

    task automatic measure_level(input int ch, input int budget, output int n);
        logic start;
        logic hit;
        start = clk_out[ch];
        n = -1;
        hit = 1'b0;
        for (int i = 1; i <= budget && !hit; i++) begin
            step();
            if (clk_out[ch] !== start) begin
                n = i;
                hit = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;
        #12;
        checks++;
        if ({cfg_if.cfg_ready, cfg_if.cfg_err, base_tick, tick, clk_out} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {cfg_if.cfg_ready, cfg_if.cfg_err, base_tick, tick, clk_out}, 9'b1_0000_0000);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n;
        send(2'd0, 8'd3, 1'b1);
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_after_accept got=%b exp=0", cfg_if.cfg_ready);
        end
        step();
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_after_apply got=%b exp=1", cfg_if.cfg_ready);
        end
        wait_ev(0, 40, n);
        checks++;
        if (clk_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_toggle got=%b exp=1 (wait=%0d)", clk_out[0], n);
        end
        measure_level(0, 40, n);
        checks++;
        if (n !== 12 || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_high_time got=%0d tick=%b exp=12 tick=1", n, tick[0]);
        end
        measure_level(0, 40, n);
        checks++;
        if (n !== 12 || tick[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic_low_time got=%0d tick=%b exp=12 tick=1", n, tick[0]);
        end
        wait_ev(3, 10, n);
        wait_ev(3, 10, n);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL basic_base_tick_period got=%0d exp=4", n);
        end
    endtask

    task automatic test_retarget();
        int n;
        logic ready_low_ok;
        logic hit;
        wait_ev(0, 40, n);
        step();
        step();
        step();
        send(2'd0, 8'd1, 1'b1);
        ready_low_ok = (cfg_if.cfg_ready === 1'b0);
        n = -1;
        hit = 1'b0;
        for (int i = 1; i <= 40 && !hit; i++) begin
            step();
            if (tick[0]) begin
                n = i;
                hit = 1'b1;
            end else if (cfg_if.cfg_ready !== 1'b0) begin
                ready_low_ok = 1'b0;
            end
        end
        checks++;
        if (!ready_low_ok) begin
            failures++;
            $display("FAIL retarget_ready_held got=%b exp=1", ready_low_ok);
        end
        checks++;
        if (n !== 8 || cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL retarget_boundary got=%0d ready=%b exp=8 ready=1", n, cfg_if.cfg_ready);
        end
        wait_ev(0, 20, n);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL retarget_new_period_1 got=%0d exp=4", n);
        end
        wait_ev(0, 20, n);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL retarget_new_period_2 got=%0d exp=4", n);
        end
    endtask

    task automatic test_disable();
        int n;
        logic quiet;
        send(2'd1, 8'd2, 1'b1);
        step();
        wait_ev(1, 40, n);
        checks++;
        if (clk_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL disable_clk_high got=%b exp=1", clk_out[1]);
        end
        step();
        step();
        send(2'd1, 8'd2, 1'b0);
        wait_ev(1, 40, n);
        checks++;
        if (n !== 5 || clk_out[1] !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL disable_last_tick got=%0d clk=%b ready=%b exp=5 clk=0 ready=1",
                     n, clk_out[1], cfg_if.cfg_ready);
        end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick[1] !== 1'b0 || clk_out[1] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL disable_stays_quiet got=%b exp=1", quiet);
        end
    endtask

    task automatic test_errors();
        logic quiet;
        send(2'd3, 8'd5, 1'b1);
        checks++;
        if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got=%b ready=%b exp=1 ready=1", cfg_if.cfg_err, cfg_if.cfg_ready);
        end
        step();
        checks++;
        if (cfg_if.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL err_one_cycle got=%b exp=0", cfg_if.cfg_err);
        end
        send(2'd2, 8'd0, 1'b1);
        checks++;
        if (cfg_if.cfg_ready !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL div0_accept got ready=%b err=%b exp ready=0 err=0",
                     cfg_if.cfg_ready, cfg_if.cfg_err);
        end
        step();
        quiet = (cfg_if.cfg_ready === 1'b1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL div0_stays_disabled got=%b exp=1", quiet);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        cfg_if.cfg_ch    = 2'd2;
        cfg_if.cfg_div   = 8'd2;
        cfg_if.cfg_en    = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        step();
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_after_accept got=%b exp=0", cfg_if.cfg_ready);
        end
        step();
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_after_apply got=%b exp=1", cfg_if.cfg_ready);
        end
        cfg_if.cfg_en = 1'b0;
        step();
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept got=%b exp=0", cfg_if.cfg_ready);
        end
        wait_ev(2, 40, n);
        checks++;
        if (n < 0 || clk_out[2] !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_disable_at_first_tick got wait=%0d clk=%b ready=%b exp clk=0 ready=1",
                     n, clk_out[2], cfg_if.cfg_ready);
        end
    endtask

    task automatic test_reset_in_pend();
        logic quiet;
        send(2'd0, 8'd3, 1'b1);
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstpend_in_pend got=%b exp=0", cfg_if.cfg_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_if.cfg_ready, cfg_if.cfg_err, base_tick, tick, clk_out} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL rstpend_outputs got=%b exp=%b",
                     {cfg_if.cfg_ready, cfg_if.cfg_err, base_tick, tick, clk_out}, 9'b1_0000_0000);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick !== 3'b000 || clk_out !== 3'b000 || cfg_if.cfg_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL rstpend_no_apply got=%b exp=1", quiet);
        end
    endtask

`ifdef TICK_SCHED_ALIGN_EN
    task automatic test_align();
        int n;
        send(2'd0, 8'd2, 1'b1);
        step();
        send(2'd1, 8'd3, 1'b1);
        step();
        for (int i = 0; i < 5; i++) step();
        align = 1'b1;
        step();
        align = 1'b0;
        checks++;
        if ({base_tick, tick, clk_out} !== 7'b0) begin
            failures++;
            $display("FAIL align_clears got=%b exp=0000000", {base_tick, tick, clk_out});
        end
        wait_ev(0, 40, n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL align_ch0_first got=%0d exp=8", n);
        end
        wait_ev(1, 40, n);
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL align_ch1_first got=%0d exp=4 after ch0", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_retarget();
        test_disable();
        test_errors();
        test_back_to_back();
        test_reset_in_pend();
`ifdef TICK_SCHED_ALIGN_EN
        test_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
